// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signal bundle for sram_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and SRAM's view.
interface sram_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int AW    = 14,
    parameter int DW    = 16
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]    wr_req;
    logic [N_REQ*AW-1:0] wr_addr;
    logic [N_REQ*DW-1:0] wr_data;
    logic [N_REQ-1:0]    wr_gnt;

    logic [N_REQ-1:0]    rd_req;
    logic [N_REQ*AW-1:0] rd_addr;
    logic [N_REQ-1:0]    rd_gnt;
    logic                rd_vld;
    logic [IW-1:0]       rd_id;
    logic [DW-1:0]       rd_data;

    logic                sram_wr_en;
    logic [AW-1:0]       sram_wr_addr;
    logic [DW-1:0]       sram_din;
    logic                sram_rd_en;
    logic [AW-1:0]       sram_rd_addr;
    logic [DW-1:0]       sram_dout;
    logic                sram_rst_n;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
        output wr_gnt, rd_gnt, rd_vld, rd_id, rd_data,
        output sram_wr_en, sram_wr_addr, sram_din, sram_rd_en, sram_rd_addr, sram_rst_n
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
        input  wr_gnt, rd_gnt, rd_vld, rd_id, rd_data,
        input  sram_wr_en, sram_wr_addr, sram_din, sram_rd_en, sram_rd_addr, sram_rst_n
    );
endinterface

// File: rtl/sram_arbiter.sv
// Independent round-robin write and read arbiters in front of a single-port-per-direction SRAM.
// Grants are registered one-cycle pulses; read data is captured one cycle after its grant.
module sram_arbiter #(
    parameter int N_REQ = 4,
    parameter int AW    = 14,
    parameter int DW    = 16
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0] wr_gnt_q;
    logic [N_REQ-1:0] rd_gnt_q;
    logic [IW-1:0]    wr_ptr_q;
    logic [IW-1:0]    rd_ptr_q;
    logic [IW-1:0]    rd_sel_q;
    logic             wr_en_q;
    logic             rd_en_q;
    logic             rd_vld_q;
    logic [AW-1:0]    wr_addr_q;
    logic [AW-1:0]    rd_addr_q;
    logic [DW-1:0]    din_q;
    logic [DW-1:0]    rd_data_q;
    logic [IW-1:0]    rd_id_q;

    logic             wr_hit;
    logic             rd_hit;
    logic [IW-1:0]    wr_sel;
    logic [IW-1:0]    rd_sel;

    // Returns {hit, index} of the first eligible requester at or after ptr.
    function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] elig,
                                            input logic [IW-1:0]    ptr);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (elig[idx]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] sel);
        return (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
    endfunction

    // A requester granted in the current cycle sits out this arbitration.
    always_comb begin
        {wr_hit, wr_sel} = rr_pick(bus.wr_req & ~wr_gnt_q, wr_ptr_q);
        {rd_hit, rd_sel} = rr_pick(bus.rd_req & ~rd_gnt_q, rd_ptr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_gnt_q  <= '0;
            rd_gnt_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_sel_q  <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            din_q     <= '0;
            rd_data_q <= '0;
            rd_id_q   <= '0;
        end else begin
            wr_gnt_q <= wr_hit ? (N_REQ'(1) << wr_sel) : '0;
            wr_en_q  <= wr_hit;
            if (wr_hit) begin
                wr_ptr_q  <= next_ptr(wr_sel);
                wr_addr_q <= bus.wr_addr[int'(wr_sel)*AW +: AW];
                din_q     <= bus.wr_data[int'(wr_sel)*DW +: DW];
            end

            rd_gnt_q <= rd_hit ? (N_REQ'(1) << rd_sel) : '0;
            rd_en_q  <= rd_hit;
            if (rd_hit) begin
                rd_ptr_q  <= next_ptr(rd_sel);
                rd_addr_q <= bus.rd_addr[int'(rd_sel)*AW +: AW];
                rd_sel_q  <= rd_sel;
            end

            // SRAM presents the granted word on the falling edge of the grant cycle.
            rd_vld_q <= rd_en_q;
            if (rd_en_q) begin
                rd_data_q <= bus.sram_dout;
                rd_id_q   <= rd_sel_q;
            end
        end
    end

    assign bus.wr_gnt       = wr_gnt_q;
    assign bus.rd_gnt       = rd_gnt_q;
    assign bus.rd_vld       = rd_vld_q;
    assign bus.rd_id        = rd_id_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.sram_wr_en   = wr_en_q;
    assign bus.sram_wr_addr = wr_addr_q;
    assign bus.sram_din     = din_q;
    assign bus.sram_rd_en   = rd_en_q;
    assign bus.sram_rd_addr = rd_addr_q;
    assign bus.sram_rst_n   = ~rst;
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of write requesters and the number of read requesters (2..8).
REQ-002 The block SHALL have parameter AW, default 14, giving the SRAM address width.
REQ-003 The block SHALL have parameter DW, default 16, giving the SRAM data width.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 The block SHALL have port wr_req  input  N_REQ  per-requester write request, held until granted.
REQ-007 The block SHALL have port wr_addr  input  N_REQ*AW  per-requester write address; slice i = bits [i*AW +: AW].
REQ-008 The block SHALL have port wr_data  input  N_REQ*DW  per-requester write data; slice i = bits [i*DW +: DW].
REQ-009 The block SHALL have port wr_gnt  output  N_REQ  one-hot write grant, one-cycle pulse.
REQ-010 The block SHALL have port rd_req  input  N_REQ  per-requester read request, held until granted.
REQ-011 The block SHALL have port rd_addr  input  N_REQ*AW  per-requester read address; slice i = bits [i*AW +: AW].
REQ-012 The block SHALL have port rd_gnt  output  N_REQ  one-hot read grant, one-cycle pulse.
REQ-013 The block SHALL have port rd_vld  output  1  read data valid.
REQ-014 The block SHALL have port rd_id  output  clog2(N_REQ)  index of the requester that owns rd_data.
REQ-015 The block SHALL have port rd_data  output  DW  registered read data.
REQ-016 The block SHALL have SRAM-side ports sram_wr_en (output, 1), sram_wr_addr (output, AW), sram_din (output, DW), sram_rd_en (output, 1), sram_rd_addr (output, AW), sram_dout (input, DW) and sram_rst_n (output, 1, = ~rst, combinational).

Function
REQ-017 Cycle N SHALL denote the interval following rising edge N.
REQ-018 Write and read arbitration SHALL be independent; at most one write grant and at most one read grant SHALL be issued per cycle.
REQ-019 At edge N the arbiter SHALL sample wr_req/rd_req and register the grant, so that wr_gnt[i], sram_wr_en=1, sram_wr_addr=slice i and sram_din=slice i are all driven during cycle N.
REQ-020 A requester whose gnt bit is high during the sampling edge SHALL be excluded from that arbitration, so a held request is never double-granted; a single requester with continuous requests SHALL therefore be granted at most every other cycle.
REQ-021 Each port SHALL use round-robin arbitration: search starts at pointer ptr; after a grant to index i, ptr SHALL become (i+1) mod N_REQ; with no grant, ptr SHALL be unchanged.
REQ-022 Any request held continuously SHALL be granted within 2*N_REQ cycles.
REQ-023 When no request is eligible, gnt SHALL be 0 and the SRAM enable SHALL be 0, and the SRAM address/data outputs SHALL hold their previous values.
REQ-024 For a read granted in cycle N (the SRAM updates sram_dout on the falling edge in cycle N), at edge N+1 the block SHALL capture rd_data=sram_dout and rd_id=granted index, and SHALL drive rd_vld=1 for cycle N+1 only.
REQ-025 The fixed read latency SHALL be 1 cycle from rd_gnt to rd_vld; back-to-back reads SHALL produce back-to-back rd_vld.
REQ-026 A read and a write to the same address granted in the same cycle SHALL return the old data (read-before-write); no forwarding is provided.
REQ-027 rd_data and rd_id SHALL hold their values when rd_vld=0.

Reset
REQ-028 While rst=1, wr_gnt, rd_gnt, sram_wr_en, sram_rd_en and rd_vld SHALL be 0; rd_data, rd_id, sram_wr_addr, sram_rd_addr and sram_din SHALL be 0; both ptr registers SHALL be 0.
REQ-029 Reset asserted while a read is in flight SHALL suppress its rd_vld, and no grant SHALL issue in the first cycle after reset deasserts unless a request is sampled at that edge.

Verification
REQ-030 Single write: wr_req[2]=1, addr 0x0010, data 0xBEEF -> wr_gnt=4'b0100, sram_wr_en=1 for exactly one cycle; a later read from requester 0 at 0x0010 -> rd_vld=1, rd_id=0, rd_data=0xBEEF one cycle after rd_gnt.
REQ-031 All four wr_req held high -> grant order 0,1,2,3,0,... with no index granted twice before all others have been granted.
REQ-032 Simultaneous rd_req[1] and wr_req[3] to 0x3FFF (old 0x1111, new 0x2222) -> both granted in the same cycle, rd_data=0x1111; a subsequent read returns 0x2222.
REQ-033 A single requester holding rd_req continuously -> rd_gnt high on alternating cycles only, with each rd_vld one cycle after its grant.
REQ-034 rst pulsed in the cycle after rd_gnt -> rd_vld stays 0, all outputs are 0, and the next grant after reset goes to requester 0 when all requests are high.
